relobi_route_stage: RTL
=======================

Name: relobi_route_stage

Overview:
- Registered, redundancy-parametrised address-routing stage for the reliable OBI crossbar. It sits between the subordinate-port A-channel inputs and the per-port demux select inputs.
- Per subordinate port it does four things:
  - ECC-decodes the address.
  - Decodes it against NumCopies independent address maps.
  - Registers the per-copy select, abort and decode-error results behind a valid/ready handshake.
  - Counts and reports ECC faults and copy disagreements.
- It extends the combinational TMR select path with pipelining, selectable abort policy and fault statistics.

Parameters:
- NumSbrPorts, 4, number of subordinate ports (lanes); each lane is independent.
- NumMgrPorts, 4, number of manager ports; SelWidth = max(1, $clog2(NumMgrPorts)).
- AddrWidth, 32, plain address width.
- EccAddrWidth, AddrWidth + hsiao_ecc_pkg::min_ecc(AddrWidth), encoded address width.
- NumAddrRules, 4, rules per map copy.
- addr_map_rule_t, logic, rule struct with idx, start_addr, end_addr.
- NumCopies, 3, map/decoder redundancy; legal values 1 or 3 (elaboration error otherwise).
- AbortMode, 1, abort policy:
  - 0: never abort; decode the corrected address.
  - 1: abort on uncorrectable error; decode the corrected address.
  - 2: abort on any ECC error; decode the raw address bits.
- FaultCntWidth, 8, width of each saturating per-lane fault counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- sbr_valid_i  in  NumSbrPorts  lane address valid
- sbr_ready_o  out  NumSbrPorts  lane accepts address
- sbr_addr_i  in  NumSbrPorts x EccAddrWidth  ECC-encoded address per lane
- addr_map_i  in  NumCopies x NumAddrRules x $bits(addr_map_rule_t)  address map, one per copy
- en_default_idx_i  in  NumCopies x NumSbrPorts  default-index enable
- default_idx_i  in  NumCopies x NumSbrPorts x SelWidth  default index
- sel_valid_o  out  NumSbrPorts  registered result valid
- sel_ready_i  in  NumSbrPorts  consumer accepts result
- sel_idx_o  out  NumCopies x NumSbrPorts x SelWidth  per-copy select (kept unvoted for downstream TMR)
- sel_abort_o  out  NumCopies x NumSbrPorts  per-copy abort
- sel_dec_error_o  out  NumSbrPorts  voted no-rule-match and default disabled
- fault_o  out  2  [0] correctable fault pulse, [1] uncorrectable fault pulse
- fault_cnt_clr_i  in  1  synchronous clear of all counters
- fault_cnt_o  out  NumSbrPorts x FaultCntWidth  per-lane fault count

Behaviour:
- Reset values: sel_valid_o=0, sel_idx_o=0, sel_abort_o=0, sel_dec_error_o=0, fault_o=0, fault_cnt_o=0.
- Each lane has one output register, so latency is 1 cycle.
  - Accept condition: sbr_valid_i & sbr_ready_o.
  - sbr_ready_o = ~sel_valid_o | sel_ready_i (combinational from sel_ready_i, full throughput).
- On accept, the register loads new results and sel_valid_o goes to 1.
- If sel_valid_o & sel_ready_i & ~accept, sel_valid_o goes to 0.
- While sel_valid_o=1 & ~sel_ready_i, all sel_* outputs hold stable.
- Per copy c, hsiao_ecc_dec on sbr_addr_i gives corrected address, err[0] (single-bit corrected) and err[1] (uncorrectable).
- The decode address is the raw bits [AddrWidth-1:0] if AbortMode=2, otherwise the corrected address.
- addr_decode is run per copy with map copy c; sel_idx_o[c] is its idx_o.
- Abort, per copy:
  - sel_abort_o[c] = err[1] for AbortMode 1.
  - sel_abort_o[c] = err[0]|err[1] for AbortMode 2.
  - sel_abort_o[c] = 0 for AbortMode 0.
- Decode error: sel_dec_error_o is the bitwise majority over copies of dec_error_o, or copy 0 when NumCopies=1.
- Copy mismatch exists when NumCopies=3 and the idx or dec_error values of the three copies are not all equal.
- Fault pulses on an accepted beat, registered, high for exactly 1 cycle:
  - fault_o[0]: any lane had err[0] or a copy mismatch.
  - fault_o[1]: any lane had err[1].
  - No pulse on idle cycles or stalled holds.
- Counters, per lane:
  - +1 on an accepted beat with any err bit set or a copy mismatch.
  - Saturate at all-ones with no wrap.
  - On fault_cnt_clr_i alone, the counter becomes 0.
  - If clear and increment happen in the same cycle, the counter becomes 1.
- Lanes never interact except through the shared fault_o OR and the shared clear.
- If reset is asserted mid-transfer, the pending result is discarded and all outputs go to reset values asynchronously.

Optional Feature:
- Macro: RELOBI_ROUTE_FAULT_CNT_EN.
- When defined: the counters and fault_cnt_clr_i behave as specified.
- When undefined:
  - No counter flops are instantiated.
  - fault_cnt_o is tied to 0 and fault_cnt_clr_i is ignored.
  - fault_o and all other behaviour are unchanged.

Test Plan:
- Clean routing, NumCopies=3, AbortMode=1, maps 0x0000-0x0FFF->0 and 0x1000-0x1FFF->1. Lane0 valid with encoded 0x1004, sel_ready_i=1 -> next cycle sel_valid_o[0]=1, all three sel_idx_o=1, abort=0, fault_o=0.
- Single-bit error: flip addr bit 3 of encoded 0x1004, AbortMode=1 -> idx=1, abort=0, fault_o=2'b01 for 1 cycle, fault_cnt_o[0]=1.
- Double-bit error: flip bits 3 and 7.
  - AbortMode=1: all sel_abort_o=1, fault_o=2'b10.
  - AbortMode=2 with a single flip: abort=1 and idx decoded from the raw address.
- Copy mismatch: copy 2 map rule1 maps to idx 2 -> sel_idx_o copy2=2, others=1, fault_o[0]=1, counter increments.
- Backpressure: sel_ready_i=0 for 5 cycles with lane valid asserted -> sbr_ready_o=0, outputs stable, a single fault_o pulse only. Release -> back-to-back beats at 1 per cycle.
- Counter edges:
  - FaultCntWidth=2: 5 faulty beats -> saturates at 3.
  - Clear coincident with a faulty beat -> 1.
  - Async reset mid-hold -> sel_valid_o=0 immediately.

Source files
------------

// File: rtl/relobi_route_stage.sv
// Registered ECC-decode and address-routing stage for the reliable OBI crossbar.
// Define RELOBI_ROUTE_FAULT_CNT_EN to build the per-lane saturating fault counters.
module relobi_route_stage #(
    parameter int unsigned NumSbrPorts   = 4,
    parameter int unsigned NumMgrPorts   = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned EccAddrWidth  =
        AddrWidth + $clog2(AddrWidth + $clog2(AddrWidth) + 1) + 1,
    parameter int unsigned NumAddrRules  = 4,
    parameter int unsigned NumCopies     = 3,
    parameter int unsigned AbortMode     = 1,
    parameter int unsigned FaultCntWidth = 8,
    localparam int unsigned SelWidth     = (NumMgrPorts > 1) ? $clog2(NumMgrPorts) : 1,
    // Rule layout, MSB first: {idx[31:0], start_addr, end_addr}
    localparam int unsigned RuleWidth    = 32 + 2 * AddrWidth
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [NumSbrPorts-1:0]                              sbr_valid_i,
    output logic [NumSbrPorts-1:0]                              sbr_ready_o,
    input  logic [NumSbrPorts-1:0][EccAddrWidth-1:0]            sbr_addr_i,
    input  logic [NumCopies-1:0][NumAddrRules-1:0][RuleWidth-1:0] addr_map_i,
    input  logic [NumCopies-1:0][NumSbrPorts-1:0]               en_default_idx_i,
    input  logic [NumCopies-1:0][NumSbrPorts-1:0][SelWidth-1:0] default_idx_i,
    output logic [NumSbrPorts-1:0]                              sel_valid_o,
    input  logic [NumSbrPorts-1:0]                              sel_ready_i,
    output logic [NumCopies-1:0][NumSbrPorts-1:0][SelWidth-1:0] sel_idx_o,
    output logic [NumCopies-1:0][NumSbrPorts-1:0]               sel_abort_o,
    output logic [NumSbrPorts-1:0]                              sel_dec_error_o,
    output logic [1:0]                                          fault_o,
    input  logic                                                fault_cnt_clr_i,
    output logic [NumSbrPorts-1:0][FaultCntWidth-1:0]           fault_cnt_o
);

    localparam int unsigned EccBits = EccAddrWidth - AddrWidth;

    if (NumCopies != 1 && NumCopies != 3) begin : g_bad_copies
        $error("relobi_route_stage: NumCopies must be 1 or 3");
    end
    if (AbortMode > 2) begin : g_bad_abort
        $error("relobi_route_stage: AbortMode must be 0, 1 or 2");
    end
    if (EccBits < 3 || ((2 ** (EccBits - 1)) - EccBits) < AddrWidth) begin : g_bad_ecc
        $error("relobi_route_stage: EccAddrWidth too small for a SEC-DED code");
    end

    // Hsiao column for data bit n: the n-th odd-weight (>= 3) vector in ascending order.
    function automatic logic [EccBits-1:0] data_col(int unsigned bit_idx);
        logic [EccBits-1:0] col;
        logic [EccBits-1:0] vec;
        int unsigned        cnt;
        col = '0;
        cnt = 0;
        for (int unsigned v = 1; v < (1 << EccBits); v++) begin
            vec = EccBits'(v);
            if ($countones(vec) >= 3 && ($countones(vec) % 2) == 1) begin
                if (cnt == bit_idx) col = vec;
                cnt++;
            end
        end
        return col;
    endfunction

    logic [AddrWidth-1:0][EccBits-1:0] h_col;
    for (genvar i = 0; i < AddrWidth; i++) begin : g_col
        localparam logic [EccBits-1:0] Col = data_col(i);
        assign h_col[i] = Col;
    end

    logic [NumCopies-1:0][NumSbrPorts-1:0][SelWidth-1:0] idx_d;
    logic [NumCopies-1:0][NumSbrPorts-1:0]               abort_d;
    logic [NumCopies-1:0][NumSbrPorts-1:0]               dec_err_copy;
    logic [NumCopies-1:0][NumSbrPorts-1:0]               err_corr;
    logic [NumCopies-1:0][NumSbrPorts-1:0]               err_unc;
    logic [NumSbrPorts-1:0] dec_err_d, mismatch, lane_corr, lane_unc, accept;

    for (genvar c = 0; c < NumCopies; c++) begin : g_copy
        for (genvar l = 0; l < NumSbrPorts; l++) begin : g_lane
            logic [EccBits-1:0]   syndrome;
            logic [AddrWidth-1:0] corrected;
            logic [AddrWidth-1:0] dec_addr;
            logic [SelWidth-1:0]  idx;
            logic                 matched;
            logic                 corr;
            logic                 unc;

            always_comb begin
                syndrome = sbr_addr_i[l][EccAddrWidth-1:AddrWidth];
                for (int unsigned i = 0; i < AddrWidth; i++) begin
                    if (sbr_addr_i[l][i]) syndrome = syndrome ^ h_col[i];
                end
            end

            always_comb begin
                corrected = sbr_addr_i[l][AddrWidth-1:0];
                for (int unsigned i = 0; i < AddrWidth; i++) begin
                    if (syndrome == h_col[i]) corrected[i] = ~corrected[i];
                end
            end

            // Later rules override earlier ones; end_addr == 0 means open-ended.
            always_comb begin
                dec_addr = (AbortMode == 2) ? sbr_addr_i[l][AddrWidth-1:0] : corrected;
                idx      = en_default_idx_i[c][l] ? default_idx_i[c][l] : '0;
                matched  = 1'b0;
                for (int unsigned r = 0; r < NumAddrRules; r++) begin
                    if ((dec_addr >= addr_map_i[c][r][2*AddrWidth-1:AddrWidth]) &&
                        ((dec_addr < addr_map_i[c][r][AddrWidth-1:0]) ||
                         (addr_map_i[c][r][AddrWidth-1:0] == '0))) begin
                        idx     = addr_map_i[c][r][2*AddrWidth +: SelWidth];
                        matched = 1'b1;
                    end
                end
            end

            assign corr = ^syndrome;
            assign unc  = (|syndrome) & ~(^syndrome);

            assign idx_d[c][l]        = idx;
            assign err_corr[c][l]     = corr;
            assign err_unc[c][l]      = unc;
            assign dec_err_copy[c][l] = ~matched & ~en_default_idx_i[c][l];
            assign abort_d[c][l]      = (AbortMode == 1) ? unc :
                                        (AbortMode == 2) ? (corr | unc) : 1'b0;
        end
    end

    for (genvar l = 0; l < NumSbrPorts; l++) begin : g_vote
        if (NumCopies == 3) begin : g_tmr
            assign dec_err_d[l] = (dec_err_copy[0][l] & dec_err_copy[1][l]) |
                                  (dec_err_copy[0][l] & dec_err_copy[2][l]) |
                                  (dec_err_copy[1][l] & dec_err_copy[2][l]);
            assign mismatch[l]  = (idx_d[0][l] != idx_d[1][l]) ||
                                  (idx_d[0][l] != idx_d[2][l]) ||
                                  (dec_err_copy[0][l] != dec_err_copy[1][l]) ||
                                  (dec_err_copy[0][l] != dec_err_copy[2][l]);
        end else begin : g_single
            assign dec_err_d[l] = dec_err_copy[0][l];
            assign mismatch[l]  = 1'b0;
        end
    end

    always_comb begin
        lane_corr = '0;
        lane_unc  = '0;
        for (int unsigned c = 0; c < NumCopies; c++) begin
            lane_corr = lane_corr | err_corr[c];
            lane_unc  = lane_unc | err_unc[c];
        end
    end

    logic unused_idx_bits;
    always_comb begin
        unused_idx_bits = 1'b0;
        for (int unsigned c = 0; c < NumCopies; c++) begin
            for (int unsigned r = 0; r < NumAddrRules; r++) begin
                unused_idx_bits = unused_idx_bits ^
                                  (^addr_map_i[c][r][RuleWidth-1:2*AddrWidth+SelWidth]);
            end
        end
    end

    assign sbr_ready_o = ~sel_valid_o | sel_ready_i;
    assign accept      = sbr_valid_i & sbr_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_valid_o     <= '0;
            sel_idx_o       <= '0;
            sel_abort_o     <= '0;
            sel_dec_error_o <= '0;
            fault_o         <= '0;
        end else begin
            sel_valid_o <= accept | (sel_valid_o & ~sel_ready_i);
            fault_o     <= {|(accept & lane_unc), |(accept & (lane_corr | mismatch))};
            for (int unsigned l = 0; l < NumSbrPorts; l++) begin
                if (accept[l]) begin
                    sel_dec_error_o[l] <= dec_err_d[l];
                    for (int unsigned c = 0; c < NumCopies; c++) begin
                        sel_idx_o[c][l]   <= idx_d[c][l];
                        sel_abort_o[c][l] <= abort_d[c][l];
                    end
                end
            end
        end
    end

`ifdef RELOBI_ROUTE_FAULT_CNT_EN
    logic [NumSbrPorts-1:0][FaultCntWidth-1:0] cnt_d, cnt_q;

    // A clear coinciding with a faulty beat leaves a count of one.
    always_comb begin
        logic inc;
        cnt_d = cnt_q;
        for (int unsigned l = 0; l < NumSbrPorts; l++) begin
            inc = accept[l] & (lane_corr[l] | lane_unc[l] | mismatch[l]);
            if (fault_cnt_clr_i) begin
                cnt_d[l] = inc ? FaultCntWidth'(1) : '0;
            end else if (inc && (cnt_q[l] != '1)) begin
                cnt_d[l] = cnt_q[l] + FaultCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign fault_cnt_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = fault_cnt_clr_i;
    assign fault_cnt_o    = '0;
`endif

endmodule
